// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one registered data-memory bus access per EX/MEM op, load data aligned and extended for MEM/WB.
// Latency: 2 cycles plus ack wait (misaligned: 1 cycle). Backpressure: stall holds the pipeline while an op is in IDLE or BUSY.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [1:0]  load_size,
    input  logic        load_signed,
    input  logic [31:0] alu_result,
    input  logic [31:0] rd_two,
    output logic        stall,
    output logic [31:0] mem_rdata,
    output logic        done,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_t      state_q, state_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        done_q, done_d;
    logic        misalign_err_q, misalign_err_d;
    logic        bus_err_q, bus_err_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] cnt_q, cnt_d;

    logic        mem_op;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        misaligned;
    logic [3:0]  be_st;
    logic [31:0] wdata_rep;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic        unused_func3;

    assign unused_func3 = func3[2];
    assign mem_op = ex_valid & (mem_read | mem_write);
    assign off    = alu_result[1:0];
    assign size   = mem_write ? func3[1:0] : load_size;

    always_comb begin
        misaligned = 1'b0;
        be_st      = 4'b1111;
        wdata_rep  = rd_two;
        case (size)
            2'b00: begin
                be_st     = 4'b0001 << off;
                wdata_rep = {4{rd_two[7:0]}};
            end
            2'b01: begin
                misaligned = off[0];
                be_st      = 4'b0011 << off;
                wdata_rep  = {2{rd_two[15:0]}};
            end
            2'b10: misaligned = (off != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Shift the addressed lane down to bit 0 before extension.
    assign shifted = dm_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = shifted;
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        dm_req_d       = dm_req_q;
        dm_we_d        = dm_we_q;
        dm_addr_d      = dm_addr_q;
        dm_be_d        = dm_be_q;
        dm_wdata_d     = dm_wdata_q;
        mem_rdata_d    = mem_rdata_q;
        done_d         = 1'b0;
        misalign_err_d = 1'b0;
        bus_err_d      = 1'b0;
        off_d          = off_q;
        size_d         = size_q;
        signed_d       = signed_q;
        cnt_d          = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        mem_rdata_d    = 32'd0;
                        misalign_err_d = 1'b1;
                        done_d         = 1'b1;
                        state_d        = S_DONE;
                    end else begin
                        dm_req_d   = 1'b1;
                        dm_we_d    = mem_write;
                        dm_addr_d  = {alu_result[31:2], 2'b00};
                        dm_be_d    = mem_write ? be_st : 4'b0000;
                        dm_wdata_d = wdata_rep;
                        off_d      = off;
                        size_d     = size;
                        signed_d   = load_signed;
                        cnt_d      = 32'd0;
                        state_d    = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                // An ack arriving on the timeout cycle takes priority.
                if (dm_ack) begin
                    dm_req_d    = 1'b0;
                    mem_rdata_d = dm_we_q ? 32'd0 : load_ext;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
                    dm_req_d    = 1'b0;
                    mem_rdata_d = 32'd0;
                    bus_err_d   = 1'b1;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            dm_req_q       <= 1'b0;
            dm_we_q        <= 1'b0;
            dm_addr_q      <= 32'd0;
            dm_be_q        <= 4'd0;
            dm_wdata_q     <= 32'd0;
            mem_rdata_q    <= 32'd0;
            done_q         <= 1'b0;
            misalign_err_q <= 1'b0;
            bus_err_q      <= 1'b0;
            off_q          <= 2'd0;
            size_q         <= 2'd0;
            signed_q       <= 1'b0;
            cnt_q          <= 32'd0;
        end else begin
            state_q        <= state_d;
            dm_req_q       <= dm_req_d;
            dm_we_q        <= dm_we_d;
            dm_addr_q      <= dm_addr_d;
            dm_be_q        <= dm_be_d;
            dm_wdata_q     <= dm_wdata_d;
            mem_rdata_q    <= mem_rdata_d;
            done_q         <= done_d;
            misalign_err_q <= misalign_err_d;
            bus_err_q      <= bus_err_d;
            off_q          <= off_d;
            size_q         <= size_d;
            signed_q       <= signed_d;
            cnt_q          <= cnt_d;
        end
    end

    assign stall        = ((state_q == S_IDLE) & mem_op) | (state_q == S_BUSY);
    assign mem_rdata    = mem_rdata_q;
    assign done         = done_q;
    assign misalign_err = misalign_err_q;
    assign bus_err      = bus_err_q;
    assign dm_req       = dm_req_q;
    assign dm_we        = dm_we_q;
    assign dm_addr      = dm_addr_q;
    assign dm_be        = dm_be_q;
    assign dm_wdata     = dm_wdata_q;

endmodule
